// File: rtl/vga_capture_if.sv
// rtl/vga_capture_if.sv - capture control and buffer readout bus for vga_capture
interface vga_capture_if #(
  parameter int BUF_DEPTH = 64
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  logic [9:0]    cap_x;
  logic [9:0]    cap_y;
  logic [CW-1:0] cap_len;
  logic          cap_start;
  logic          cap_busy;
  logic          cap_done;
  logic [CW-1:0] cap_count;
  logic [AW-1:0] buf_addr;
  logic [11:0]   buf_rdata;

  modport master (
    output cap_x, cap_y, cap_len, cap_start, buf_addr,
    input  cap_busy, cap_done, cap_count, buf_rdata
  );

  modport slave (
    input  cap_x, cap_y, cap_len, cap_start, buf_addr,
    output cap_busy, cap_done, cap_count, buf_rdata
  );
endinterface

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - passive VGA sink: sync timing measurement, lock detect, pixel-run capture
// Optional visible-frame checksum enabled by defining VGA_CAPTURE_CHECKSUM_EN.
module vga_capture #(
  parameter int H_START   = 200,
  parameter int V_START   = 29,
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 600,
  parameter int BUF_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  vga_red,
  input  logic [3:0]  vga_green,
  input  logic [3:0]  vga_blue,
  input  logic        h_sync,
  input  logic        v_sync,
  vga_capture_if.slave cap,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic [15:0] frame_sum
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [11:0]   H_LO  = 12'(H_START);
  localparam logic [10:0]   V_LO  = 11'(V_START);
  localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [2:0] {IDLE, ARMED, SEEK, CAPTURE, DONE} state_e;

  logic [11:0] s_rgb_q;
  logic        s_hs_q, s_vs_q, prev_hs_q, prev_vs_q;
  logic        hs_fall, vs_fall;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [11:0] line_len_q;
  logic [10:0] frame_lines_q;
  logic        locked_q, line_stable_q;

  state_e        state_q, state_d;
  logic [9:0]    cx_q, cx_d, cy_q, cy_d;
  logic [CW-1:0] len_q, len_d, count_q, count_d, req_len;
  logic          match, wr_en;
  logic [11:0]   mem_q [BUF_DEPTH];
  logic [11:0]   rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_rgb_q   <= '0;
      s_hs_q    <= 1'b1;
      s_vs_q    <= 1'b1;
      prev_hs_q <= 1'b1;
      prev_vs_q <= 1'b1;
    end else begin
      s_rgb_q   <= {vga_red, vga_green, vga_blue};
      s_hs_q    <= h_sync;
      s_vs_q    <= v_sync;
      prev_hs_q <= s_hs_q;
      prev_vs_q <= s_vs_q;
    end
  end

  assign hs_fall = prev_hs_q & ~s_hs_q;
  assign vs_fall = prev_vs_q & ~s_vs_q;

  // h_cnt_d / v_cnt_d are the counts belonging to the current sample; the _q
  // copies hold the previous sample's count, i.e. the length just finished.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (hs_fall)                h_cnt_d = '0;
    else if (h_cnt_q != 12'hFFF) h_cnt_d = h_cnt_q + 12'd1;
    if (vs_fall)                          v_cnt_d = '0;
    else if (hs_fall && v_cnt_q != 11'h7FF) v_cnt_d = v_cnt_q + 11'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= 12'hFFF;
      v_cnt_q       <= 11'h7FF;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      locked_q      <= 1'b0;
      line_stable_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (hs_fall) line_len_q <= h_cnt_q + 12'd1;
      if (vs_fall) begin
        frame_lines_q <= v_cnt_q;
        locked_q      <= line_stable_q & (v_cnt_q == frame_lines_q) & (v_cnt_q != 11'd0);
        line_stable_q <= 1'b1;
      end else if (hs_fall && (h_cnt_q + 12'd1 != line_len_q)) begin
        line_stable_q <= 1'b0;
      end
    end
  end

  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;

  assign match   = (h_cnt_d == H_LO + {2'b00, cx_q}) && (v_cnt_d == V_LO + {1'b0, cy_q});
  assign req_len = (cap.cap_len > DEPTH) ? DEPTH : cap.cap_len;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    len_d   = len_q;
    count_d = count_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (cap.cap_start) begin
          cx_d    = cap.cap_x;
          cy_d    = cap.cap_y;
          len_d   = req_len;
          count_d = '0;
          state_d = (req_len == '0) ? DONE : ARMED;
        end
      end
      ARMED: if (vs_fall) state_d = SEEK;
      SEEK: begin
        if (vs_fall) begin
          state_d = DONE;
        end else if (match) begin
          wr_en   = 1'b1;
          count_d = ONE;
          state_d = (len_q == ONE) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        // A new line ends the run; the sync-edge sample itself is not stored.
        if (hs_fall) begin
          state_d = DONE;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + ONE;
          if (count_q + ONE == len_q) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= s_rgb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem_q[cap.buf_addr];
  end

  assign cap.cap_busy  = (state_q == ARMED) || (state_q == SEEK) || (state_q == CAPTURE);
  assign cap.cap_done  = (state_q == DONE);
  assign cap.cap_count = count_q;
  assign cap.buf_rdata = rdata_q;

`ifdef VGA_CAPTURE_CHECKSUM_EN
  localparam logic [11:0] H_HI = 12'(H_START + H_ACTIVE);
  localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);
  logic [15:0] acc_q, frame_sum_q;
  logic        in_win;

  assign in_win = (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) && (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      frame_sum_q <= '0;
    end else if (vs_fall) begin
      frame_sum_q <= acc_q;
      acc_q       <= '0;
    end else if (in_win) begin
      acc_q <= acc_q + {4'b0000, s_rgb_q};
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = '0;
`endif
endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - directed self-checking bench for vga_capture on a reduced 32x20 raster
module tb_vga_capture;
  localparam int HT = 32, HA = 20, HS0 = 22, HSW = 4;
  localparam int VT = 20, VA = 12, VS0 = 15, VSW = 2;
  localparam int BD = 8;
`ifdef VGA_CAPTURE_CHECKSUM_EN
  localparam logic [15:0] SUM_X = 16'h08E8, SUM_W = 16'hFF10, SUM_K = 16'h0000;
`else
  localparam logic [15:0] SUM_X = 16'h0000, SUM_W = 16'h0000, SUM_K = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vga_red = '0, vga_green = '0, vga_blue = '0;
  logic        h_sync = 1'b1, v_sync = 1'b1;
  logic [11:0] line_len;
  logic [10:0] frame_lines;
  logic        locked;
  logic [15:0] frame_sum;

  int checks = 0, failures = 0;
  int hc = 0, vc = 0, drv_hc = 0, drv_vc = 0, mode = 0;
  bit short_en = 1'b0;

  vga_capture_if #(.BUF_DEPTH(BD)) cif ();

  vga_capture #(
    .H_START(HT - HS0), .V_START(VT - VS0), .H_ACTIVE(HA), .V_ACTIVE(VA), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .h_sync(h_sync), .v_sync(v_sync),
    .cap(cif),
    .line_len(line_len), .frame_lines(frame_lines), .locked(locked), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pos(input int v, input int h);
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk); #1;
      if (drv_vc == v && drv_hc == h) found = 1'b1;
    end
    if (!found) check("wait_pos", found, 1'b1);
  endtask

  task automatic start_cap(input int x, input int y, input int len);
    wait_pos(VS0 + 1, 0);
    cif.cap_x = 10'(x); cif.cap_y = 10'(y); cif.cap_len = 4'(len);
    cif.cap_start = 1'b1;
    @(negedge clk);
    cif.cap_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (cif.cap_done === 1'b1) seen = 1'b1;
    end
    check(tag, cif.cap_done, 1'b1);
  endtask

  task automatic read_buf(input string tag, input int addr, input logic [11:0] exp);
    @(negedge clk);
    cif.buf_addr = 3'(addr);
    @(posedge clk); #1;
    check(tag, cif.buf_rdata, exp);
  endtask

  initial begin
    cif.cap_x = '0; cif.cap_y = '0; cif.cap_len = '0; cif.cap_start = 1'b0; cif.buf_addr = '0;
    fork
      forever begin
        logic [11:0] pix;
        @(negedge clk);
        drv_hc = hc; drv_vc = vc;
        pix = 12'h000;
        if (hc < HA && vc < VA) pix = (mode == 0) ? 12'(hc) : (mode == 1) ? 12'hFFF : 12'h000;
        {vga_red, vga_green, vga_blue} = pix;
        h_sync = !(hc >= HS0 && hc < HS0 + HSW);
        v_sync = !(vc >= VS0 && vc < VS0 + VSW);
        if (hc == ((short_en && vc == 7) ? HT - 2 : HT - 1)) begin
          hc = 0;
          vc = (vc == VT - 1) ? 0 : vc + 1;
        end else begin
          hc++;
        end
      end
    join_none

    repeat (4) @(posedge clk); #1;
    check("rst_busy", cif.cap_busy, 1'b0);
    check("rst_done", cif.cap_done, 1'b0);
    check("rst_count", cif.cap_count, 4'd0);
    check("rst_line_len", line_len, 12'd0);
    check("rst_frame_lines", frame_lines, 11'd0);
    check("rst_locked", locked, 1'b0);
    check("rst_frame_sum", frame_sum, 16'd0);
    check("rst_rdata", cif.buf_rdata, 12'd0);

    wait_pos(0, 0);
    rst = 1'b0;
    wait_pos(VS0 + 1, 0);
    check("vs1_frame_lines_sat", frame_lines, 11'h7FF);
    check("vs1_line_len", line_len, 12'(HT));
    check("vs1_locked", locked, 1'b0);
    wait_pos(VS0 + 1, 0);
    check("vs2_frame_lines", frame_lines, 11'(VT));
    check("vs2_locked", locked, 1'b0);
    wait_pos(VS0 + 1, 0);
    check("vs3_locked", locked, 1'b1);

    short_en = 1'b1;
    wait_pos(8, HS0 + 4);
    check("short_line_len", line_len, 12'(HT - 1));
    wait_pos(9, 0);
    short_en = 1'b0;
    wait_pos(VS0 + 1, 0);
    check("short_unlocked", locked, 1'b0);
    check("short_frame_lines", frame_lines, 11'(VT));
    wait_pos(VS0 + 1, 0);
    check("relocked", locked, 1'b1);

    start_cap(5, 3, 4); #1;
    check("basic_busy", cif.cap_busy, 1'b1);
    check("basic_done_cleared", cif.cap_done, 1'b0);
    wait_done("basic_done");
    check("basic_count", cif.cap_count, 4'd4);
    for (int i = 0; i < 4; i++) read_buf("basic_buf", i, 12'(5 + i));

    start_cap(16, 3, 12);
    wait_done("trunc_done");
    check("trunc_count", cif.cap_count, 4'd6);
    read_buf("trunc_buf3", 3, 12'd19);
    read_buf("trunc_buf4", 4, 12'd0);

    start_cap(0, 4, 12);
    wait_done("clamp_done");
    check("clamp_count", cif.cap_count, 4'd8);
    read_buf("clamp_buf7", 7, 12'd7);

    start_cap(25, 3, 5);
    wait_done("oor_done");
    check("oor_count", cif.cap_count, 4'd0);
    check("oor_busy", cif.cap_busy, 1'b0);

    start_cap(2, 1, 3);
    wait_pos(VS0 + 2, 0);
    cif.cap_x = 10'd9; cif.cap_len = 4'd1; cif.cap_start = 1'b1;
    @(negedge clk);
    cif.cap_start = 1'b0;
    wait_done("ignore_done");
    check("ignore_count", cif.cap_count, 4'd3);
    for (int i = 0; i < 3; i++) read_buf("ignore_buf", i, 12'(2 + i));

    wait_pos(VS0 + 1, 0);
    wait_pos(VS0 + 1, 0);
    check("sum_ramp", frame_sum, SUM_X);
    mode = 1;
    wait_pos(VS0 + 1, 0);
    check("sum_white", frame_sum, SUM_W);
    mode = 2;
    wait_pos(VS0 + 1, 0);
    check("sum_black", frame_sum, SUM_K);
    mode = 0;

    start_cap(0, 2, 8);
    wait_pos(VS0, 5);
    wait_pos(2, 4);
    check("mid_busy", cif.cap_busy, 1'b1);
    check("mid_count", cif.cap_count, 4'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", cif.cap_busy, 1'b0);
    check("rst_mid_done", cif.cap_done, 1'b0);
    check("rst_mid_count", cif.cap_count, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    start_cap(3, 3, 0); #1;
    check("len0_done", cif.cap_done, 1'b1);
    check("len0_busy", cif.cap_busy, 1'b0);
    check("len0_count", cif.cap_count, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
